// File: rtl/bool_func_checker_if.sv
// rtl/bool_func_checker_if.sv - sweep control, UUT stimulus/response and result signals of the checker
interface bool_func_checker_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic                 f;
  logic [N_IN-1:0]      stim;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2**N_IN-1:0]   truth_table;
  logic [N_IN-1:0]      fail_idx;
  logic [N_IN:0]        mismatch_cnt;

  modport master (
    output start, f,
    input  stim, busy, done, pass, truth_table, fail_idx, mismatch_cnt
  );

  modport slave (
    input  start, f,
    output stim, busy, done, pass, truth_table, fail_idx, mismatch_cnt
  );
endinterface

// File: rtl/bool_func_checker.sv
// rtl/bool_func_checker.sv - exhaustive truth-table sweep of a combinational UUT against a golden table
module bool_func_checker #(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8
) (
  input logic                clk,
  input logic                rst,
  bool_func_checker_if.slave bus
);
  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FIN} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [NV-1:0]     tt_q, tt_d;
  logic [N_IN-1:0]   fidx_q, fidx_d;
  logic [N_IN:0]     mcnt_q, mcnt_d;
  logic              failed_q, failed_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      stim_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tt_q     <= '0;
      fidx_q   <= '0;
      mcnt_q   <= '0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tt_q     <= tt_d;
      fidx_q   <= fidx_d;
      mcnt_q   <= mcnt_d;
      failed_q <= failed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    tt_d     = tt_q;
    fidx_d   = fidx_q;
    mcnt_d   = mcnt_q;
    failed_d = failed_q;
    case (state_q)
      IDLE: begin
        // done is still high in the first IDLE cycle; a start there must not launch a sweep
        if (bus.start && !done_q) begin
          state_d  = WAIT;
          stim_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          tt_d     = '0;
          fidx_d   = '0;
          mcnt_d   = '0;
          failed_d = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(SETTLE)) state_d = SAMPLE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      SAMPLE: begin
        tt_d[stim_q] = bus.f;
        if (bus.f != EXPECTED[stim_q]) begin
          mcnt_d = mcnt_q + 1'b1;
          if (!failed_q) begin
            fidx_d   = stim_q;
            failed_d = 1'b1;
          end
        end
        if (stim_q == N_IN'(NV - 1)) begin
          state_d = FIN;
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (mcnt_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim         = stim_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.truth_table  = tt_q;
  assign bus.fail_idx     = fidx_q;
  assign bus.mismatch_cnt = mcnt_q;
endmodule

// File: tb/tb_bool_func_checker.sv
// tb/tb_bool_func_checker.sv - directed sweeps of bool_func_checker with a result scoreboard
module tb_bool_func_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bool_func_checker_if #(.N_IN(3)) bus0 ();
  bool_func_checker_if #(.N_IN(3)) bus1 ();

  bool_func_checker #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bool_func_checker #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hE8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [7:0] tt;
    int         cnt;
    int         idx;
    logic       pass;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;

  // mode 0 majority, 1 majority inverted at vector 5, 2 tied 0, 3 tied 1
  function automatic logic uut(logic [2:0] v, int m);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      1:       return maj ^ (v == 3'd5);
      2:       return 1'b0;
      3:       return 1'b1;
      default: return maj;
    endcase
  endfunction

  assign bus0.f = uut(bus0.stim, mode);
  assign bus1.f = uut(bus1.stim, mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    logic [31:0] acc;
    acc = {8'd0, bus0.truth_table, 1'b0, bus0.stim, 1'b0, bus0.fail_idx,
           bus0.mismatch_cnt, bus0.busy, bus0.done, bus0.pass};
    chk(tag, acc, 32'd0);
  endtask

  task automatic sweep(input bit sel, input bit extra, input logic [7:0] tt,
                       input int cnt, input int idx, input logic pass, input int lat_exp);
    int   lat;
    logic dn;
    logic busy_seen;
    exp_t e;
    exp_q.push_back('{tt, cnt, idx, pass, lat_exp});
    if (sel) bus1.start = 1'b1; else bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    chk("busy_after_start", sel ? bus1.busy : bus0.busy, 1);
    chk("stim_after_start", sel ? bus1.stim : bus0.stim, 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      dn = sel ? bus1.done : bus0.done;
      if (sel && lat <= 15) chk($sformatf("stim_seq_%0d", lat), bus1.stim, lat / 2);
      if (extra) bus0.start = (lat == 5 || lat == 20 || dn);
    end while (!dn && lat < 200);
    if (!dn) chk("done_timeout", 0, 1);
    e = exp_q.pop_front();
    chk("latency",      lat, e.lat);
    chk("truth_table",  sel ? bus1.truth_table  : bus0.truth_table,  e.tt);
    chk("mismatch_cnt", sel ? bus1.mismatch_cnt : bus0.mismatch_cnt, e.cnt);
    chk("fail_idx",     sel ? bus1.fail_idx     : bus0.fail_idx,     e.idx);
    chk("pass",         sel ? bus1.pass         : bus0.pass,         e.pass);
    chk("busy_at_done", sel ? bus1.busy         : bus0.busy,         0);
    @(posedge clk); #1;
    bus0.start = 1'b0;
    chk("done_one_cycle", sel ? bus1.done : bus0.done, 0);
    if (extra) begin
      busy_seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        busy_seen = busy_seen | bus0.busy | bus0.done;
      end
      chk("no_second_sweep", busy_seen, 0);
      chk("results_hold", bus0.truth_table, 8'hE8);
    end
  endtask

  initial begin
    logic done_seen;
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    chk("reset_dut1", {bus1.busy, bus1.done, bus1.pass}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    mode = 0; sweep(0, 0, 8'hE8, 0, 0, 1'b1, 33);
    mode = 1; sweep(0, 0, 8'hC8, 1, 5, 1'b0, 33);
    mode = 2; sweep(0, 0, 8'h00, 4, 3, 1'b0, 33);
    mode = 3; sweep(0, 0, 8'hFF, 4, 0, 1'b0, 33);
    mode = 0; sweep(0, 1, 8'hE8, 0, 0, 1'b1, 33);

    // reset mid-sweep: asynchronous clear between clock edges, no done afterwards
    mode = 1;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_reset_mid_sweep");
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      done_seen = done_seen | bus0.done | bus0.busy;
    end
    chk("no_done_after_reset", done_seen, 0);
    mode = 0; sweep(0, 0, 8'hE8, 0, 0, 1'b1, 33);

    mode = 0; sweep(1, 0, 8'hE8, 0, 0, 1'b1, 17);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
